// File: rtl/mc_ctrl_pkg.sv
// Purpose : shared types/encodings for the multicycle main control FSM.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: state enum (4-bit), mux-select encodings, ImmSrc/Op codes,
//           control-vector struct and the Op->ImmSrc helper.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    ILLEGAL  = 4'd10
  } state_t;

  localparam logic [1:0] SRCA_RD1    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] IMM_DP = 2'b00;
  localparam logic [1:0] IMM_LS = 2'b01;
  localparam logic [1:0] IMM_BR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_LS  = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // Raw per-state control vector; fetch strobes are gated by mem_ready in the top.
  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  // Illegal opcode reuses the DP extender setting; the value is don't-care there.
  function automatic logic [1:0] imm_src_of(input logic [1:0] op);
    case (op)
      OP_LS:   imm_src_of = IMM_LS;
      OP_BR:   imm_src_of = IMM_BR;
      default: imm_src_of = IMM_DP;
    endcase
  endfunction

endpackage

// File: rtl/mc_main_fsm_if.sv
// Purpose : control/datapath signal bundle between the main FSM and the datapath.
// Latency : n/a (wires only).
// Backpressure: mem_ready is the only stall input.
// Modports: master = FSM side (drives strobes/selects), slave = datapath side.
interface mc_main_fsm_if;
  import mc_ctrl_pkg::*;

  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       IRWrite;
  logic       NextPC;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic       ALUOp;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       illegal;

  modport master (
    input  Op, Funct, mem_ready,
    output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
           ALUOp, RegW, MemW, Branch, illegal
  );

  modport slave (
    output Op, Funct, mem_ready,
    input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
           ALUOp, RegW, MemW, Branch, illegal
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Purpose : combinational state -> raw control-vector table (Moore decode).
// Latency : 0 cycles, purely combinational.
// Backpressure: none here; stall gating is applied by the caller.
// Ports   : state (in, current FSM state), ctrl (out, ungated control vector).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.next_pc    = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURES;
      end
      DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURES;
      end
      MEMADR: begin
        ctrl.alu_src_a  = SRCA_RD1;
        ctrl.alu_src_b  = SRCB_EXTIMM;
      end
      MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
      end
      MEMWRITE: begin
        // Held through every wait cycle; memory commits on the ready cycle.
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_w      = 1'b1;
      end
      EXECR: begin
        ctrl.alu_src_a  = SRCA_RD1;
        ctrl.alu_src_b  = SRCB_RD2;
        ctrl.alu_op     = 1'b1;
      end
      EXECI: begin
        ctrl.alu_src_a  = SRCA_RD1;
        ctrl.alu_src_b  = SRCB_EXTIMM;
        ctrl.alu_op     = 1'b1;
      end
      ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w      = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a  = SRCA_ALUOUT;
        ctrl.alu_src_b  = SRCB_EXTIMM;
        ctrl.result_src = RES_ALURES;
        ctrl.branch     = 1'b1;
      end
      ILLEGAL: begin
        ctrl.illegal    = 1'b1;
      end
      default: ctrl = '0;  // unused encodings drive nothing
    endcase
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Purpose : multicycle main control FSM (fetch/decode/execute/memory/writeback).
// Latency : DP 4, LDR 5, STR 4, B 3, illegal 3 cycles without stalls.
// Backpressure: holds in FETCH/MEMREAD/MEMWRITE until mem_ready=1.
// Ports   : clk, reset (sync, active-high), bus (mc_main_fsm_if.master),
//           instr_retired[PERF_W-1:0] only when MC_PERF_CNT_EN is defined.
// Config  : MC_PERF_CNT_EN adds the retired-instruction counter.
module mc_main_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  mc_main_fsm_if.master     bus
`ifdef MC_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] instr_retired
`endif
);

  if (PERF_W < 1) begin : g_bad_perf_w
    $error("PERF_W must be at least 1");
  end

  state_t state;
  state_t state_n;
  ctrl_t  ctrl;

  // Only I (bit 5) and L (bit 0) steer the sequence.
  logic funct_unused;
  assign funct_unused = ^bus.Funct[4:1];

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      FETCH:    if (bus.mem_ready) state_n = DECODE;
      DECODE: begin
        case (bus.Op)
          OP_DP:   state_n = bus.Funct[5] ? EXECI : EXECR;
          OP_LS:   state_n = MEMADR;
          OP_BR:   state_n = BRANCH;
          default: state_n = ILLEGAL;
        endcase
      end
      MEMADR:   state_n = bus.Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  if (bus.mem_ready) state_n = MEMWB;
      MEMWRITE: if (bus.mem_ready) state_n = FETCH;
      EXECR,
      EXECI:    state_n = ALUWB;
      ALUWB,
      MEMWB,
      BRANCH,
      ILLEGAL:  state_n = FETCH;
      default:  state_n = FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  // Strobes are forced low during reset; fetch strobes also wait for memory.
  assign bus.IRWrite   = ~reset & ctrl.ir_write & bus.mem_ready;
  assign bus.NextPC    = ~reset & ctrl.next_pc  & bus.mem_ready;
  assign bus.RegW      = ~reset & ctrl.reg_w;
  assign bus.MemW      = ~reset & ctrl.mem_w;
  assign bus.Branch    = ~reset & ctrl.branch;
  assign bus.illegal   = ~reset & ctrl.illegal;
  assign bus.AdrSrc    = ctrl.adr_src;
  assign bus.ALUSrcA   = ctrl.alu_src_a;
  assign bus.ALUSrcB   = ctrl.alu_src_b;
  assign bus.ResultSrc = ctrl.result_src;
  assign bus.ALUOp     = ctrl.alu_op;
  assign bus.ImmSrc    = imm_src_of(bus.Op);

`ifdef MC_PERF_CNT_EN
  // An instruction retires on the cycle its final state hands back to FETCH.
  logic retire;
  assign retire = (state == ALUWB) || (state == MEMWB) || (state == BRANCH) ||
                  ((state == MEMWRITE) && bus.mem_ready);

  always_ff @(posedge clk) begin
    if (reset)       instr_retired <= '0;
    else if (retire) instr_retired <= instr_retired + PERF_W'(1);
  end
`endif

endmodule

// File: tb/tb_mc_main_fsm.sv
// Purpose : directed, table-driven check of mc_main_fsm control sequencing.
// Latency : n/a.
// Backpressure: mem_ready stalls are exercised in FETCH and MEMWRITE.
module tb_mc_main_fsm;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mc_main_fsm_if bus ();

`ifdef MC_PERF_CNT_EN
  logic [31:0] instr_retired;
`endif

  mc_main_fsm #(.PERF_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MC_PERF_CNT_EN
    ,
    .instr_retired (instr_retired)
`endif
  );

  // {IRWrite,NextPC,AdrSrc,A[2],B[2],Res[2],Imm[2],ALUOp,RegW,MemW,Branch,illegal}
  function automatic logic [15:0] ctl_now();
    return {bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB,
            bus.ResultSrc, bus.ImmSrc, bus.ALUOp, bus.RegW, bus.MemW,
            bus.Branch, bus.illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        mr;
    state_t      st;
    logic [15:0] ctl;
  } vec_t;

  vec_t vecs[27];

  initial begin
    // LDR
    vecs[0]  = '{2'b01, 6'b011001, 1'b1, FETCH,    16'b1_1_0_01_10_10_01_0_0_0_0_0};
    vecs[1]  = '{2'b01, 6'b011001, 1'b1, DECODE,   16'b0_0_0_01_10_10_01_0_0_0_0_0};
    vecs[2]  = '{2'b01, 6'b011001, 1'b1, MEMADR,   16'b0_0_0_00_01_00_01_0_0_0_0_0};
    vecs[3]  = '{2'b01, 6'b011001, 1'b1, MEMREAD,  16'b0_0_1_00_00_00_01_0_0_0_0_0};
    vecs[4]  = '{2'b01, 6'b011001, 1'b1, MEMWB,    16'b0_0_0_00_00_01_01_0_1_0_0_0};
    // STR with three wait cycles in MEMWRITE
    vecs[5]  = '{2'b01, 6'b011000, 1'b1, FETCH,    16'b1_1_0_01_10_10_01_0_0_0_0_0};
    vecs[6]  = '{2'b01, 6'b011000, 1'b1, DECODE,   16'b0_0_0_01_10_10_01_0_0_0_0_0};
    vecs[7]  = '{2'b01, 6'b011000, 1'b1, MEMADR,   16'b0_0_0_00_01_00_01_0_0_0_0_0};
    vecs[8]  = '{2'b01, 6'b011000, 1'b0, MEMWRITE, 16'b0_0_1_00_00_00_01_0_0_1_0_0};
    vecs[9]  = '{2'b01, 6'b011000, 1'b0, MEMWRITE, 16'b0_0_1_00_00_00_01_0_0_1_0_0};
    vecs[10] = '{2'b01, 6'b011000, 1'b0, MEMWRITE, 16'b0_0_1_00_00_00_01_0_0_1_0_0};
    vecs[11] = '{2'b01, 6'b011000, 1'b1, MEMWRITE, 16'b0_0_1_00_00_00_01_0_0_1_0_0};
    // DP immediate
    vecs[12] = '{2'b00, 6'b101000, 1'b1, FETCH,    16'b1_1_0_01_10_10_00_0_0_0_0_0};
    vecs[13] = '{2'b00, 6'b101000, 1'b1, DECODE,   16'b0_0_0_01_10_10_00_0_0_0_0_0};
    vecs[14] = '{2'b00, 6'b101000, 1'b1, EXECI,    16'b0_0_0_00_01_00_00_1_0_0_0_0};
    vecs[15] = '{2'b00, 6'b101000, 1'b1, ALUWB,    16'b0_0_0_00_00_00_00_0_1_0_0_0};
    // DP register
    vecs[16] = '{2'b00, 6'b001000, 1'b1, FETCH,    16'b1_1_0_01_10_10_00_0_0_0_0_0};
    vecs[17] = '{2'b00, 6'b001000, 1'b1, DECODE,   16'b0_0_0_01_10_10_00_0_0_0_0_0};
    vecs[18] = '{2'b00, 6'b001000, 1'b1, EXECR,    16'b0_0_0_00_00_00_00_1_0_0_0_0};
    vecs[19] = '{2'b00, 6'b001000, 1'b1, ALUWB,    16'b0_0_0_00_00_00_00_0_1_0_0_0};
    // Branch
    vecs[20] = '{2'b10, 6'b000000, 1'b1, FETCH,    16'b1_1_0_01_10_10_10_0_0_0_0_0};
    vecs[21] = '{2'b10, 6'b000000, 1'b1, DECODE,   16'b0_0_0_01_10_10_10_0_0_0_0_0};
    vecs[22] = '{2'b10, 6'b000000, 1'b1, BRANCH,   16'b0_0_0_10_01_10_10_0_0_0_1_0};
    // Illegal opcode: single-cycle pulse, then back to FETCH (stalled there)
    vecs[23] = '{2'b11, 6'b000000, 1'b1, FETCH,    16'b1_1_0_01_10_10_00_0_0_0_0_0};
    vecs[24] = '{2'b11, 6'b000000, 1'b1, DECODE,   16'b0_0_0_01_10_10_00_0_0_0_0_0};
    vecs[25] = '{2'b11, 6'b000000, 1'b1, ILLEGAL,  16'b0_0_0_00_00_00_00_0_0_0_0_1};
    vecs[26] = '{2'b11, 6'b000000, 1'b0, FETCH,    16'b0_0_0_01_10_10_00_0_0_0_0_0};

    // Reset with mem_ready high: fetch strobes must stay low.
    reset = 1'b1;
    bus.Op = 2'b00;
    bus.Funct = 6'b000000;
    bus.mem_ready = 1'b1;
    tick();
    check("reset strobes", {28'd0, bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW}, 32'd0);
    tick();
    check("reset state", {28'd0, dut.state}, {28'd0, FETCH});
`ifdef MC_PERF_CNT_EN
    check("reset count", instr_retired, 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 27; i++) begin
      bus.Op = vecs[i].op;
      bus.Funct = vecs[i].funct;
      bus.mem_ready = vecs[i].mr;
      #1;
      check($sformatf("row%0d state", i), {28'd0, dut.state}, {28'd0, vecs[i].st});
      check($sformatf("row%0d ctrl", i), {16'd0, ctl_now()}, {16'd0, vecs[i].ctl});
      tick();
    end

`ifdef MC_PERF_CNT_EN
    // LDR, STR, DP imm, DP reg and B retire; the illegal op does not.
    check("retired count", instr_retired, 32'd5);
`endif

    // Reset while stalled in MEMWRITE.
    bus.Op = 2'b01;
    bus.Funct = 6'b011000;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.mem_ready = 1'b0;
    #1;
    check("in memwrite", {28'd0, dut.state}, {28'd0, MEMWRITE});
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.mem_ready = (c != 0);
      #1;
      check($sformatf("rst%0d MemW", c), {31'd0, bus.MemW}, 32'd0);
      check($sformatf("rst%0d IRWrite", c), {31'd0, bus.IRWrite}, 32'd0);
      tick();
    end
    check("rst state", {28'd0, dut.state}, {28'd0, FETCH});
`ifdef MC_PERF_CNT_EN
    check("rst count", instr_retired, 32'd0);
`endif
    reset = 1'b0;

    // FETCH stall: two cycles without ready, then ready.
    bus.Op = 2'b00;
    bus.Funct = 6'b001000;
    for (int c = 0; c < 2; c++) begin
      bus.mem_ready = 1'b0;
      #1;
      check($sformatf("stall%0d state", c), {28'd0, dut.state}, {28'd0, FETCH});
      check($sformatf("stall%0d IR/NPC", c), {30'd0, bus.IRWrite, bus.NextPC}, 32'd0);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    check("ready IR/NPC", {30'd0, bus.IRWrite, bus.NextPC}, 32'd3);
    tick();
    check("after stall", {28'd0, dut.state}, {28'd0, DECODE});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
